// File: rtl/key_cond_pkg.sv
// Shared types and sizing helpers for the key conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  // Counter width: one bit above what the largest terminal count needs, so no counter can wrap.
  function automatic int cnt_width(input int deb, input int dly, input int per);
    int m;
    m = deb;
    if (dly > m) m = dly;
    if (per > m) m = per;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_cond_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, press/release strobes; optional auto-repeat (KEY_COND_AUTO_REPEAT_EN).
// Latency: press strobe is visible in the cycle after edge DEB_CYCLES+2, counting edge 0 as the first edge that samples the pin low.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
module key_cond_ch
  import key_cond_pkg::*;
#(
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_key_pressed,
  output logic o_key_press,
  output logic o_key_release
);

  localparam int CW = cnt_width(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
`ifdef KEY_COND_AUTO_REPEAT_EN
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
`endif

  logic          r_sync1;
  logic          r_sync2;
  key_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pressed;
  logic          r_press;
  logic          r_release;
`ifdef KEY_COND_AUTO_REPEAT_EN
  logic [CW-1:0] r_rcnt;
  logic          r_rep;   // 0: waiting for the first repeat, 1: in periodic phase
`endif

  // Two-flop synchroniser; resets to the released (high) level so reset exit never looks like a press.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with registered level/strobe outputs and optional repeat counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef KEY_COND_AUTO_REPEAT_EN
      r_rcnt    <= '0;
      r_rep     <= 1'b0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        RELEASED: begin
`ifdef KEY_COND_AUTO_REPEAT_EN
          r_rcnt <= '0;
          r_rep  <= 1'b0;
`endif
          if (!r_sync2) begin
            r_state <= PRESS_CHK;
            r_cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (r_sync2) begin
            r_state <= RELEASED;
          end else if (r_cnt == DEB_LAST) begin
            r_state   <= PRESSED;
            r_pressed <= 1'b1;
            r_press   <= 1'b1;
`ifdef KEY_COND_AUTO_REPEAT_EN
            r_rcnt    <= '0;
            r_rep     <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (r_sync2) begin
            r_state <= RELEASE_CHK;
            r_cnt   <= '0;
          end
`ifdef KEY_COND_AUTO_REPEAT_EN
          else if (r_rcnt == (r_rep ? PER_LAST : DLY_LAST)) begin
            r_press <= 1'b1;
            r_rcnt  <= '0;
            r_rep   <= 1'b1;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
`endif
        end
        RELEASE_CHK: begin
          if (!r_sync2) begin
            r_state <= PRESSED;
          end else if (r_cnt == DEB_LAST) begin
            r_state   <= RELEASED;
            r_pressed <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RELEASED;
      endcase
    end
  end

  assign o_key_pressed = r_pressed;
  assign o_key_press   = r_press;
  assign o_key_release = r_release;

endmodule

// File: rtl/key_conditioner.sv
// Push-button front end: N_KEYS independent debounced channels; auto-repeat enabled by KEY_COND_AUTO_REPEAT_EN.
// Latency: DEB_CYCLES+3 edges from first low sample to the press strobe; release symmetric.
// Backpressure: none; outputs are registered level plus single-cycle strobes.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS        = 3,
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  // One fully independent channel per key; no cross-key logic.
  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_cond_ch #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_key_n      (key_n[g]),
      .o_key_pressed(key_pressed[g]),
      .o_key_press  (key_press[g]),
      .o_key_release(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat constants.
// Inputs driven and outputs sampled on the falling clock edge.
// Auto-repeat expectations follow KEY_COND_AUTO_REPEAT_EN.
module tb_key_conditioner;
  localparam int N   = 3;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key_n;
  logic [N-1:0] key_pressed;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;

  key_conditioner #(
    .N_KEYS(N), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .key_pressed(key_pressed), .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tick_no;
  int pc[N];
  int rc[N];
  int fp[N];
  int fr[N];
  int overlap;
  int total_overlap = 0;
  int pt[$];

  task automatic clear_obs();
    tick_no = 0;
    overlap = 0;
    pt.delete();
    for (int c = 0; c < N; c++) begin
      pc[c] = 0; rc[c] = 0; fp[c] = -1; fr[c] = -1;
    end
  endtask

  // Advance n falling edges, recording strobes. Tick k follows posedge k-1 after the last drive.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      tick_no++;
      for (int c = 0; c < N; c++) begin
        if (key_press[c]) begin
          pc[c]++;
          if (fp[c] < 0) fp[c] = tick_no;
        end
        if (key_release[c]) begin
          rc[c]++;
          if (fr[c] < 0) fr[c] = tick_no;
        end
      end
      if (key_press[1]) pt.push_back(tick_no);
      if ((key_press & key_release) != '0) begin
        overlap++;
        total_overlap++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = 3'b000;
    clear_obs();
    run(3);
    checks++;
    if (key_pressed !== 3'b000) begin failures++; $display("FAIL reset_pressed: got %b want 000", key_pressed); end
    checks++;
    if (pc[0] + pc[1] + pc[2] + rc[0] + rc[1] + rc[2] !== 0) begin failures++; $display("FAIL reset_strobes: got %0d pulses want 0", pc[0]+pc[1]+pc[2]+rc[0]+rc[1]+rc[2]); end
    key_n = 3'b111;
    rst_n = 1'b1;
    clear_obs();
    run(4);
    checks++;
    if (key_pressed !== 3'b000 || pc[0] + pc[1] + pc[2] !== 0) begin failures++; $display("FAIL reset_exit: pressed=%b presses=%0d want 000/0", key_pressed, pc[0]+pc[1]+pc[2]); end
  endtask

  task automatic test_clean_press();
    clear_obs();
    key_n[1] = 1'b0;
    run(12);
    checks++;
    if (fp[1] !== 7) begin failures++; $display("FAIL clean_press_latency: got tick %0d want 7", fp[1]); end
    checks++;
    if (pc[1] !== 1) begin failures++; $display("FAIL clean_press_count: got %0d want 1", pc[1]); end
    checks++;
    if (key_pressed !== 3'b010) begin failures++; $display("FAIL clean_press_level: got %b want 010", key_pressed); end
    checks++;
    if (pc[0] !== 0 || pc[2] !== 0) begin failures++; $display("FAIL clean_press_others: got ch0=%0d ch2=%0d want 0/0", pc[0], pc[2]); end
    clear_obs();
    key_n[1] = 1'b1;
    run(10);
    checks++;
    if (fr[1] !== 7 || rc[1] !== 1) begin failures++; $display("FAIL clean_release: tick=%0d count=%0d want 7/1", fr[1], rc[1]); end
  endtask

  task automatic test_bounce();
    clear_obs();
    key_n[0] = 1'b0; run(3);
    key_n[0] = 1'b1; run(1);
    key_n[0] = 1'b0; run(3);
    key_n[0] = 1'b1; run(8);
    checks++;
    if (pc[0] !== 0) begin failures++; $display("FAIL bounce_no_press: got %0d want 0", pc[0]); end
    checks++;
    if (key_pressed[0] !== 1'b0) begin failures++; $display("FAIL bounce_level: got %b want 0", key_pressed[0]); end
    clear_obs();
    key_n[0] = 1'b0;
    run(10);
    checks++;
    if (pc[0] !== 1 || fp[0] !== 7) begin failures++; $display("FAIL bounce_then_press: count=%0d tick=%0d want 1/7", pc[0], fp[0]); end
    key_n[0] = 1'b1;
    run(10);
  endtask

  task automatic test_release();
    key_n[2] = 1'b0;
    run(10);
    clear_obs();
    key_n[2] = 1'b1; run(3);
    key_n[2] = 1'b0; run(2);
    key_n[2] = 1'b1; run(6);
    checks++;
    if (rc[2] !== 0 || pc[2] !== 0) begin failures++; $display("FAIL release_glitch: rel=%0d press=%0d want 0/0", rc[2], pc[2]); end
    checks++;
    if (key_pressed[2] !== 1'b1) begin failures++; $display("FAIL release_glitch_level: got %b want 1", key_pressed[2]); end
    run(4);
    checks++;
    if (fr[2] !== 12 || rc[2] !== 1) begin failures++; $display("FAIL release_after_glitch: tick=%0d count=%0d want 12/1", fr[2], rc[2]); end
    checks++;
    if (key_pressed[2] !== 1'b0) begin failures++; $display("FAIL release_level: got %b want 0", key_pressed[2]); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    key_n[1] = 1'b0;
    run(4);
    rst_n = 1'b0;
    run(2);
    checks++;
    if (pc[1] !== 0 || key_pressed[1] !== 1'b0) begin failures++; $display("FAIL reset_mid_during: presses=%0d level=%b want 0/0", pc[1], key_pressed[1]); end
    rst_n = 1'b1;
    clear_obs();
    run(10);
    checks++;
    if (fp[1] !== 7 || pc[1] !== 1) begin failures++; $display("FAIL reset_mid_restart: tick=%0d count=%0d want 7/1", fp[1], pc[1]); end
    key_n[1] = 1'b1;
    run(10);
  endtask

  task automatic test_simultaneous();
    clear_obs();
    key_n[1] = 1'b0;
    key_n[2] = 1'b0;
    run(10);
    checks++;
    if (fp[1] !== 7 || fp[2] !== 7) begin failures++; $display("FAIL simultaneous_press: ch1=%0d ch2=%0d want 7/7", fp[1], fp[2]); end
    checks++;
    if (pc[0] !== 0 || key_pressed !== 3'b110) begin failures++; $display("FAIL simultaneous_level: ch0=%0d level=%b want 0/110", pc[0], key_pressed); end
    clear_obs();
    key_n[1] = 1'b1;
    key_n[2] = 1'b1;
    run(10);
    checks++;
    if (fr[1] !== 7 || fr[2] !== 7) begin failures++; $display("FAIL simultaneous_release: ch1=%0d ch2=%0d want 7/7", fr[1], fr[2]); end
  endtask

  task automatic test_auto_repeat();
    int exp_t[$];
    exp_t.delete();
    exp_t.push_back(7);
`ifdef KEY_COND_AUTO_REPEAT_EN
    for (int t = 17; t <= 40; t += RP) exp_t.push_back(t);
`endif
    clear_obs();
    key_n[1] = 1'b0;
    run(40);
    checks++;
    if (pt.size() !== exp_t.size()) begin failures++; $display("FAIL repeat_count: got %0d want %0d", pt.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size(); i++) begin
      checks++;
      if (i >= pt.size()) begin
        failures++; $display("FAIL repeat_pulse_%0d: got none want tick %0d", i, exp_t[i]);
      end else if (pt[i] !== exp_t[i]) begin
        failures++; $display("FAIL repeat_pulse_%0d: got tick %0d want %0d", i, pt[i], exp_t[i]);
      end
    end
    checks++;
    if (key_pressed[1] !== 1'b1) begin failures++; $display("FAIL repeat_level: got %b want 1", key_pressed[1]); end
    key_n[1] = 1'b1;
    run(10);
    checks++;
    if (total_overlap !== 0) begin failures++; $display("FAIL press_release_overlap: got %0d want 0", total_overlap); end
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 3'b111;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_reset_mid();
    test_simultaneous();
    test_auto_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule
